// File: rtl/loop_pkg.sv
// Shared types for the loop sequencer: frame layout, FSM states and the
// per-frame step-size helper.
package loop_pkg;

  // Frame fields are stored at a fixed maximum width; the sequencer uses
  // only the low BITS / PC_BITS bits of each field.
  localparam int unsigned LOOP_MAX_BITS    = 32;
  localparam int unsigned LOOP_MAX_PC_BITS = 32;

  typedef struct packed {
    logic [LOOP_MAX_BITS-1:0]    remaining;
    logic [LOOP_MAX_BITS-1:0]    iteration;
    logic [LOOP_MAX_PC_BITS-1:0] start_pc;
    logic                        independent;
  } loop_frame_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_ERROR  = 2'd3
  } loop_state_t;

  // Iterations consumed by one trip of a frame: a whole superscalar group
  // for independent loops, a single iteration otherwise.
  function automatic logic [LOOP_MAX_BITS-1:0] step_size(
    input logic        independent,
    input int unsigned log_width
  );
    if (independent) begin
      step_size = 32'd1 << log_width;
    end else begin
      step_size = 32'd1;
    end
  endfunction

endpackage

// File: rtl/loop_frame_stack.sv
// LIFO of loop frames with push, pop and in-place update of the top frame.
// Also exposes the frame just below the top so the sequencer can report the
// parent's iteration in the same cycle a frame is popped.
module loop_frame_stack
  import loop_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  loop_frame_t   i_push_frame,
  input  logic          i_pop,
  input  logic          i_update,
  input  loop_frame_t   i_update_frame,
  output loop_frame_t   o_top_frame,
  output loop_frame_t   o_below_frame,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  loop_frame_t   r_frames [DEPTH];
  logic [CW-1:0] r_count;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_below_idx;

  assign w_push_idx  = IW'(r_count);
  assign w_top_idx   = IW'(r_count - CW'(1));
  assign w_below_idx = IW'(r_count - CW'(2));
  assign o_count     = r_count;

  // Frame storage and occupancy; push, pop and update are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_frames[i] <= '0;
      end
    end else if (i_push && (r_count < FULL_COUNT)) begin
      r_frames[w_push_idx] <= i_push_frame;
      r_count              <= r_count + CW'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end else if (i_update && (r_count != '0)) begin
      r_frames[w_top_idx] <= i_update_frame;
    end
  end

  // Read the top frame and its parent; empty slots read as all zeros.
  always_comb begin
    o_top_frame   = '0;
    o_below_frame = '0;
    if (r_count != '0) begin
      o_top_frame = r_frames[w_top_idx];
    end else begin
      o_top_frame = '0;
    end
    if (r_count > CW'(1)) begin
      o_below_frame = r_frames[w_below_idx];
    end else begin
      o_below_frame = '0;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Hardware loop sequencer: tracks nested start_loop/end_loop instructions,
// issues branch-back requests and retirement pulses, and latches protocol
// violations into a sticky ERROR state.
module loop_sequencer
  import loop_pkg::*;
#(
  parameter int BITS                  = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int DEPTH                 = 4,
  parameter int PC_BITS               = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_valid,
  input  logic [BITS-1:0]            start_count,
  input  logic                       start_independent,
  input  logic [PC_BITS-1:0]         start_pc,
  input  logic                       end_valid,
  output logic                       jump_valid,
  output logic [PC_BITS-1:0]         jump_pc,
  output logic                       loop_done,
  output logic [BITS-1:0]            current_iteration,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       error
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL_COUNT = DW'(DEPTH);

  loop_state_t  r_state;
  loop_state_t  w_state_next;

  loop_frame_t  w_top;
  loop_frame_t  w_below;
  loop_frame_t  w_push_frame;
  loop_frame_t  w_update_frame;
  logic [DW-1:0] w_count;
  logic [DW-1:0] w_count_next;

  logic [LOOP_MAX_BITS-1:0] w_step_full;
  logic [BITS-1:0] w_step;
  logic [BITS-1:0] w_top_remaining;
  logic [BITS-1:0] w_top_iteration;
  logic [BITS-1:0] w_rem_after;
  logic [BITS-1:0] w_iter_after;
  logic [BITS-1:0] w_iter_next;

  logic w_push;
  logic w_pop;
  logic w_update;
  logic w_violation;
  logic w_jump;
  logic w_done;

  logic                r_jump_valid;
  logic [PC_BITS-1:0]  r_jump_pc;
  logic                r_loop_done;
  logic [BITS-1:0]     r_current_iteration;
  logic                r_error;

  loop_frame_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_push_frame  (w_push_frame),
    .i_pop         (w_pop),
    .i_update      (w_update),
    .i_update_frame(w_update_frame),
    .o_top_frame   (w_top),
    .o_below_frame (w_below),
    .o_count       (w_count)
  );

  assign w_step_full     = step_size(w_top.independent, SUPERSCALAR_LOG_WIDTH);
  assign w_step          = w_step_full[BITS-1:0];
  assign w_top_remaining = w_top.remaining[BITS-1:0];
  assign w_top_iteration = w_top.iteration[BITS-1:0];
  // Only used when remaining > step, so the subtraction cannot underflow.
  assign w_rem_after     = w_top_remaining - w_step;
  assign w_iter_after    = w_top_iteration + w_step;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Decode the issued instruction into a stack operation and next state.
  always_comb begin
    w_push         = 1'b0;
    w_pop          = 1'b0;
    w_update       = 1'b0;
    w_violation    = 1'b0;
    w_jump         = 1'b0;
    w_done         = 1'b0;
    w_push_frame   = '0;
    w_update_frame = w_top;
    w_count_next   = w_count;
    w_iter_next    = r_current_iteration;
    w_state_next   = r_state;

    if (r_state != ST_ERROR) begin
      if (start_valid && end_valid) begin
        w_violation = 1'b1;
      end else if (start_valid) begin
        if (w_count == FULL_COUNT) begin
          w_violation = 1'b1;
        end else begin
          w_push                   = 1'b1;
          w_push_frame.remaining   = (start_count == '0) ? 32'd1 : 32'(start_count);
          w_push_frame.iteration   = 32'd0;
          w_push_frame.start_pc    = 32'(start_pc);
          w_push_frame.independent = start_independent;
          w_count_next             = w_count + DW'(1);
          w_iter_next              = '0;
        end
      end else if (end_valid) begin
        if (w_count == '0) begin
          w_violation = 1'b1;
        end else if (w_top_remaining > w_step) begin
          w_update                 = 1'b1;
          w_jump                   = 1'b1;
          w_update_frame.remaining = 32'(w_rem_after);
          w_update_frame.iteration = 32'(w_iter_after);
          w_iter_next              = w_iter_after;
        end else begin
          w_pop        = 1'b1;
          w_done       = 1'b1;
          w_count_next = w_count - DW'(1);
          w_iter_next  = w_below.iteration[BITS-1:0];
        end
      end else begin
        w_count_next = w_count;
      end
    end else begin
      w_count_next = w_count;
    end

    if (w_violation || (r_state == ST_ERROR)) begin
      w_state_next = ST_ERROR;
    end else if (w_count_next == '0) begin
      w_state_next = ST_EMPTY;
    end else if (w_count_next == FULL_COUNT) begin
      w_state_next = ST_FULL;
    end else begin
      w_state_next = ST_ACTIVE;
    end
  end

  // Registered outputs; pulses last exactly one cycle, jump_pc is zero
  // whenever no jump is being ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jump_valid        <= 1'b0;
      r_jump_pc           <= '0;
      r_loop_done         <= 1'b0;
      r_current_iteration <= '0;
      r_error             <= 1'b0;
    end else begin
      r_jump_valid        <= w_jump;
      r_jump_pc           <= w_jump ? w_top.start_pc[PC_BITS-1:0] : '0;
      r_loop_done         <= w_done;
      r_current_iteration <= w_iter_next;
      r_error             <= (w_state_next == ST_ERROR);
    end
  end

  assign jump_valid        = r_jump_valid;
  assign jump_pc           = r_jump_pc;
  assign loop_done         = r_loop_done;
  assign current_iteration = r_current_iteration;
  assign depth             = w_count;
  assign error             = r_error;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer (default parameters).
// Observation vector: {error, jump_valid, loop_done, depth[2:0],
// current_iteration[17:0], jump_pc[15:0]}.
module tb_loop_sequencer;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic [17:0] start_count;
  logic        start_independent;
  logic [15:0] start_pc;
  logic        end_valid;
  logic        jump_valid;
  logic [15:0] jump_pc;
  logic        loop_done;
  logic [17:0] current_iteration;
  logic [2:0]  depth;
  logic        error;

  int checks;
  int failures;
  logic [39:0] exp_v;
  wire  [39:0] obs = {error, jump_valid, loop_done, depth, current_iteration, jump_pc};

  loop_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .start_valid      (start_valid),
    .start_count      (start_count),
    .start_independent(start_independent),
    .start_pc         (start_pc),
    .end_valid        (end_valid),
    .jump_valid       (jump_valid),
    .jump_pc          (jump_pc),
    .loop_done        (loop_done),
    .current_iteration(current_iteration),
    .depth            (depth),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle with the given request; outputs are sampled 1 time unit after
  // the edge, i.e. they already show that request's registered effect.
  task automatic issue(input logic s, input logic [17:0] cnt, input logic ind,
                       input logic [15:0] pc, input logic e);
    start_valid       = s;
    start_count       = cnt;
    start_independent = ind;
    start_pc          = pc;
    end_valid         = e;
    @(posedge clk);
    #1;
    start_valid       = 1'b0;
    start_count       = 18'd0;
    start_independent = 1'b0;
    start_pc          = 16'h0000;
    end_valid         = 1'b0;
  endtask

  task automatic do_reset(input logic with_start);
    reset       = 1'b1;
    start_valid = with_start;
    start_count = 18'd5;
    start_pc    = 16'h0055;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    start_valid = 1'b0;
    start_count = 18'd0;
    start_pc    = 16'h0000;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    exp_v = {1'b0, 1'b0, 1'b0, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_simple();
    issue(1'b1, 18'd3, 1'b0, 16'h0010, 1'b0);
    exp_v = {1'b0, 1'b0, 1'b0, 3'd1, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL simple_push got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd1, 18'd1, 16'h0010};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL simple_end1 got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b0);
    exp_v = {1'b0, 1'b0, 1'b0, 3'd1, 18'd1, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL simple_idle got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd1, 18'd2, 16'h0010};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL simple_end2 got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL simple_end3 got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_independent();
    issue(1'b1, 18'd12, 1'b1, 16'h0030, 1'b0);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd1, 18'd4, 16'h0030};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL indep_end1 got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd1, 18'd8, 16'h0030};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL indep_end2 got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL indep_end3 got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_partial_and_zero();
    // 10 iterations at step 4: trips of 4, 4, 2.
    issue(1'b1, 18'd10, 1'b1, 16'h0040, 1'b0);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd1, 18'd8, 16'h0040};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL partial_end2 got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL partial_end3 got=%h exp=%h", obs, exp_v); end
    // Zero count behaves as a single iteration.
    issue(1'b1, 18'd0, 1'b0, 16'h0050, 1'b0);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL zero_count got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_nested();
    issue(1'b1, 18'd2, 1'b0, 16'h0010, 1'b0);
    issue(1'b1, 18'd2, 1'b0, 16'h0020, 1'b0);
    exp_v = {1'b0, 1'b0, 1'b0, 3'd2, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_push2 got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd2, 18'd1, 16'h0020};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_inner_jump got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd1, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_inner_done got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd1, 18'd1, 16'h0010};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_outer_jump got=%h exp=%h", obs, exp_v); end
    issue(1'b1, 18'd2, 1'b0, 16'h0020, 1'b0);
    exp_v = {1'b0, 1'b0, 1'b0, 3'd2, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_repush got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd2, 18'd1, 16'h0020};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_inner2_jump got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd1, 18'd1, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_inner2_done got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL nest_outer_done got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 18'd5, 1'b0, 16'h0100, 1'b0);
    end
    exp_v = {1'b0, 1'b0, 1'b0, 3'd4, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_full got=%h exp=%h", obs, exp_v); end
    issue(1'b1, 18'd5, 1'b0, 16'h0200, 1'b0);
    exp_v = {1'b1, 1'b0, 1'b0, 3'd4, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_fifth got=%h exp=%h", obs, exp_v); end
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL ovf_end_ignored got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_violations();
    do_reset(1'b0);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL empty_end got=%h exp=%h", obs, exp_v); end
    issue(1'b1, 18'd3, 1'b0, 16'h0060, 1'b0);
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL error_ignores_start got=%h exp=%h", obs, exp_v); end
    do_reset(1'b0);
    issue(1'b1, 18'd3, 1'b0, 16'h0070, 1'b1);
    exp_v = {1'b1, 1'b0, 1'b0, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL start_and_end got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_loop();
    do_reset(1'b0);
    issue(1'b1, 18'd3, 1'b0, 16'h0010, 1'b0);
    issue(1'b1, 18'd3, 1'b0, 16'h0020, 1'b0);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b1, 1'b0, 3'd2, 18'd1, 16'h0020};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mid_before_reset got=%h exp=%h", obs, exp_v); end
    do_reset(1'b1);
    exp_v = {1'b0, 1'b0, 1'b0, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mid_reset got=%h exp=%h", obs, exp_v); end
    issue(1'b1, 18'd1, 1'b0, 16'h0080, 1'b0);
    issue(1'b0, 18'd0, 1'b0, 16'h0000, 1'b1);
    exp_v = {1'b0, 1'b0, 1'b1, 3'd0, 18'd0, 16'h0000};
    checks++;
    if (obs !== exp_v) begin failures++; $display("FAIL mid_fresh_loop got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    start_valid       = 1'b0;
    start_count       = 18'd0;
    start_independent = 1'b0;
    start_pc          = 16'h0000;
    end_valid         = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_simple();
    test_independent();
    test_partial_and_zero();
    test_nested();
    test_overflow();
    test_violations();
    test_reset_mid_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
